// File: rtl/stack_mc_ctrl.sv
// -----------------------------------------------------------------------------
// stack_mc_ctrl
//   Multicycle control FSM for the stack-machine datapath. Decodes the 3-bit
//   IR opcode and sequences the stack pops and pushes, ALU ops, memory accesses
//   and jumps. It waits on a memory ready handshake and tracks stack occupancy
//   internally, so it can catch underflow and overflow. A stack error parks the
//   FSM in a sticky FAULT state until reset. A run input gates instruction fetch.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   run                   1 = FETCH may start a new instruction
//   opcode[2:0]           IR opcode (ADD SUB AND NOT PUSH POP JZ JMP)
//   tos[DATA_W-1:0]       current top-of-stack value (JZ zero test)
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_write    memory request valid / request is a store of tos
//   addr_src              0 = PC address, 1 = IR operand address
//   ir_write, pc_write    load IR / load PC
//   jump                  PC source = IR target
//   mdr_en                load MDR from memory data
//   load_a, load_b        latch popped value into A / B
//   push, pop, stack_src  stack strobes; push source 0 = ALU, 1 = MDR
//   alu_control[1:0]      00 ADD, 01 SUB, 10 AND, 11 NOT
//   stack_count[CNT_W-1:0] current occupancy, 0..DEPTH
//   fault, fault_code[1:0] sticky stack error (01 underflow, 10 overflow)
// -----------------------------------------------------------------------------
module stack_mc_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic [2:0]                       opcode,
    input  logic [DATA_W-1:0]                tos,
    input  logic                             mem_ready,
    output logic                             mem_req,
    output logic                             mem_write,
    output logic                             addr_src,
    output logic                             ir_write,
    output logic                             pc_write,
    output logic                             jump,
    output logic                             mdr_en,
    output logic                             load_a,
    output logic                             load_b,
    output logic                             push,
    output logic                             pop,
    output logic                             stack_src,
    output logic [1:0]                       alu_control,
    output logic [$clog2(DEPTH+1)-1:0]       stack_count,
    output logic                             fault,
    output logic [1:0]                       fault_code
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_POPA,
        S_POPB,
        S_EXEC,
        S_LOAD,
        S_PUSHM,
        S_STORE,
        S_JUMP,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       fault_code_q;
    logic [1:0]       fault_code_next;

    // State, occupancy counter and sticky fault code. The counter follows the
    // push/pop strobes, which are already forced low during reset, so a reset
    // mid-instruction drops any stack access that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_FETCH;
            count_q      <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state        <= next_state;
            fault_code_q <= fault_code_next;
            if (push) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Next-state and control decode. Everything defaults to 0 and stays 0
    // while reset is held, even though the state register already reads FETCH.
    // DECODE checks stack occupancy before committing to any pop or push, so
    // the counter can never wrap past 0 or DEPTH.
    always_comb begin
        next_state      = state;
        fault_code_next = fault_code_q;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        addr_src        = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        jump            = 1'b0;
        mdr_en          = 1'b0;
        load_a          = 1'b0;
        load_b          = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        stack_src       = 1'b0;
        alu_control     = 2'b00;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_write   = 1'b1;
                            pc_write   = 1'b1;
                            next_state = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if ((opcode == 3'b011 || opcode == 3'b101 || opcode == 3'b110)
                            && count_q < CNT_W'(1)) begin
                        next_state      = S_FAULT;
                        fault_code_next = 2'b01;
                    end else if (!opcode[2] && opcode != 3'b011 && count_q < CNT_W'(2)) begin
                        next_state      = S_FAULT;
                        fault_code_next = 2'b01;
                    end else if (opcode == 3'b100 && count_q >= CNT_W'(DEPTH)) begin
                        next_state      = S_FAULT;
                        fault_code_next = 2'b10;
                    end else if (!opcode[2]) begin
                        next_state = S_POPA;
                    end else if (opcode == 3'b100) begin
                        next_state = S_LOAD;
                    end else if (opcode == 3'b101) begin
                        next_state = S_STORE;
                    end else begin
                        next_state = S_JUMP;
                    end
                end
                S_POPA: begin
                    pop        = 1'b1;
                    load_a     = 1'b1;
                    next_state = (opcode == 3'b011) ? S_EXEC : S_POPB;
                end
                S_POPB: begin
                    pop        = 1'b1;
                    load_b     = 1'b1;
                    next_state = S_EXEC;
                end
                S_EXEC: begin
                    push        = 1'b1;
                    alu_control = opcode[1:0];
                    next_state  = S_FETCH;
                end
                S_LOAD: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    if (mem_ready) begin
                        mdr_en     = 1'b1;
                        next_state = S_PUSHM;
                    end
                end
                S_PUSHM: begin
                    push       = 1'b1;
                    stack_src  = 1'b1;
                    next_state = S_FETCH;
                end
                S_STORE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    addr_src  = 1'b1;
                    if (mem_ready) begin
                        pop        = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_JUMP: begin
                    // JMP always jumps; JZ only when tos is zero. Neither pops.
                    jump       = opcode[0] || (tos == {DATA_W{1'b0}});
                    pc_write   = opcode[0] || (tos == {DATA_W{1'b0}});
                    next_state = S_FETCH;
                end
                S_FAULT: begin
                    next_state = S_FAULT;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

    assign stack_count = count_q;
    assign fault       = (state == S_FAULT);
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_stack_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_mc_ctrl
//   Directed bench for stack_mc_ctrl (DATA_W=16, DEPTH=4). Each stimulus cycle
//   pushes the hand-derived output vector for that cycle into a queue; a monitor
//   on the falling edge pops and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_stack_mc_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset;
    logic              run;
    logic [2:0]        opcode;
    logic [DATA_W-1:0] tos;
    logic              mem_ready;
    logic              mem_req, mem_write, addr_src, ir_write, pc_write, jump;
    logic              mdr_en, load_a, load_b, push, pop, stack_src;
    logic [1:0]        alu_control;
    logic [CNT_W-1:0]  stack_count;
    logic              fault;
    logic [1:0]        fault_code;

    typedef struct packed {
        logic             mem_req;
        logic             mem_write;
        logic             addr_src;
        logic             ir_write;
        logic             pc_write;
        logic             jump;
        logic             mdr_en;
        logic             load_a;
        logic             load_b;
        logic             push;
        logic             pop;
        logic             stack_src;
        logic [1:0]       alu_control;
        logic [CNT_W-1:0] stack_count;
        logic             fault;
        logic [1:0]       fault_code;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    stack_mc_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .tos(tos),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .addr_src(addr_src), .ir_write(ir_write), .pc_write(pc_write),
        .jump(jump), .mdr_en(mdr_en), .load_a(load_a), .load_b(load_b),
        .push(push), .pop(pop), .stack_src(stack_src),
        .alu_control(alu_control), .stack_count(stack_count),
        .fault(fault), .fault_code(fault_code)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends even if the stimulus stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected stimulus to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t idle(input logic [CNT_W-1:0] c);
        out_t o;
        o = '0;
        o.stack_count = c;
        return o;
    endfunction

    function automatic out_t fault_v(input logic [CNT_W-1:0] c, input logic [1:0] code);
        out_t o;
        o = idle(c);
        o.fault = 1'b1;
        o.fault_code = code;
        return o;
    endfunction

    // Compare one expected vector against the live DUT outputs.
    task automatic checkOutput(input out_t e, input string nm);
        out_t a;
        a = '{mem_req, mem_write, addr_src, ir_write, pc_write, jump, mdr_en,
              load_a, load_b, push, pop, stack_src, alu_control, stack_count,
              fault, fault_code};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor: every falling edge with a pending expectation is checked.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic applyStimulus(input string nm, input logic rst, input logic rn,
                                 input logic [2:0] op, input logic [DATA_W-1:0] t,
                                 input logic rdy, input out_t e);
        reset     = rst;
        run       = rn;
        opcode    = op;
        tos       = t;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // FETCH with optional wait states; the opcode is scrambled here because
    // the FSM must not look at it before DECODE.
    task automatic do_fetch(input logic [2:0] op, input int waits, input logic [CNT_W-1:0] c);
        out_t e;
        for (int i = 0; i < waits; i++) begin
            e = idle(c);
            e.mem_req = 1'b1;
            applyStimulus("fetch_wait", 1'b0, 1'b1, ~op, '0, 1'b0, e);
        end
        e = idle(c);
        e.mem_req = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        applyStimulus("fetch", 1'b0, 1'b1, ~op, '0, 1'b1, e);
    endtask

    task automatic do_decode(input logic [2:0] op, input logic [CNT_W-1:0] c,
                             input logic [DATA_W-1:0] t);
        applyStimulus("decode", 1'b0, 1'b1, op, t, 1'b1, idle(c));
    endtask

    task automatic do_push(input logic [CNT_W-1:0] c, input int fw, input int lw);
        out_t e;
        do_fetch(3'b100, fw, c);
        do_decode(3'b100, c, '0);
        for (int i = 0; i < lw; i++) begin
            e = idle(c);
            e.mem_req = 1'b1;
            e.addr_src = 1'b1;
            applyStimulus("load_wait", 1'b0, 1'b1, 3'b100, '0, 1'b0, e);
        end
        e = idle(c);
        e.mem_req = 1'b1;
        e.addr_src = 1'b1;
        e.mdr_en = 1'b1;
        applyStimulus("load", 1'b0, 1'b1, 3'b100, '0, 1'b1, e);
        e = idle(c);
        e.push = 1'b1;
        e.stack_src = 1'b1;
        applyStimulus("pushm", 1'b0, 1'b1, 3'b100, '0, 1'b1, e);
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [CNT_W-1:0] c);
        out_t e;
        logic [CNT_W-1:0] cc;
        cc = c;
        do_fetch(op, 0, cc);
        do_decode(op, cc, '0);
        e = idle(cc);
        e.pop = 1'b1;
        e.load_a = 1'b1;
        applyStimulus("popa", 1'b0, 1'b1, op, '0, 1'b1, e);
        cc = cc - 1'b1;
        if (op != 3'b011) begin
            e = idle(cc);
            e.pop = 1'b1;
            e.load_b = 1'b1;
            applyStimulus("popb", 1'b0, 1'b1, op, '0, 1'b1, e);
            cc = cc - 1'b1;
        end
        e = idle(cc);
        e.push = 1'b1;
        e.alu_control = op[1:0];
        applyStimulus("exec", 1'b0, 1'b1, op, '0, 1'b1, e);
    endtask

    task automatic do_pop(input logic [CNT_W-1:0] c, input int waits);
        out_t e;
        do_fetch(3'b101, 0, c);
        do_decode(3'b101, c, '0);
        for (int i = 0; i < waits; i++) begin
            e = idle(c);
            e.mem_req = 1'b1;
            e.mem_write = 1'b1;
            e.addr_src = 1'b1;
            applyStimulus("store_wait", 1'b0, 1'b1, 3'b101, '0, 1'b0, e);
        end
        e = idle(c);
        e.mem_req = 1'b1;
        e.mem_write = 1'b1;
        e.addr_src = 1'b1;
        e.pop = 1'b1;
        applyStimulus("store", 1'b0, 1'b1, 3'b101, '0, 1'b1, e);
    endtask

    task automatic do_jump(input logic [2:0] op, input logic [DATA_W-1:0] t,
                           input logic [CNT_W-1:0] c, input logic take);
        out_t e;
        do_fetch(op, 0, c);
        do_decode(op, c, t);
        e = idle(c);
        e.jump = take;
        e.pc_write = take;
        applyStimulus("jump", 1'b0, 1'b1, op, t, 1'b1, e);
    endtask

    // Directed sequence; the stack count expected before each instruction is
    // tracked by hand in the arguments.
    initial begin
        out_t e;
        reset = 1'b1;
        run = 1'b0;
        opcode = 3'b000;
        tos = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("reset_hold", 1'b1, 1'b1, 3'b100, '0, 1'b1, idle(0));
        applyStimulus("run_low", 1'b0, 1'b0, 3'b000, '0, 1'b1, idle(0));
        applyStimulus("run_low2", 1'b0, 1'b0, 3'b100, '0, 1'b1, idle(0));

        // PUSH, PUSH, ADD: 13 cycles, counts 1, 2, 1.
        do_push(0, 0, 0);
        do_push(1, 0, 0);
        do_alu(3'b000, 2);
        applyStimulus("idle_after_add", 1'b0, 1'b0, 3'b000, '0, 1'b1, idle(1));

        // Memory wait states on both FETCH and LOAD.
        do_push(1, 3, 3);
        do_alu(3'b001, 2);
        do_push(1, 0, 0);
        do_alu(3'b010, 2);
        do_alu(3'b011, 1);
        do_pop(1, 2);

        // Jumps: JMP on an empty stack, then JZ taken / not taken.
        do_jump(3'b111, 16'h1234, 0, 1'b1);
        do_push(0, 0, 0);
        do_jump(3'b110, 16'h0100, 1, 1'b0);
        do_jump(3'b110, 16'h0000, 1, 1'b1);

        // SUB aborted by reset while in POPB.
        do_push(1, 0, 0);
        do_fetch(3'b001, 0, 2);
        do_decode(3'b001, 2, '0);
        e = idle(2);
        e.pop = 1'b1;
        e.load_a = 1'b1;
        applyStimulus("popa_sub", 1'b0, 1'b1, 3'b001, '0, 1'b1, e);
        applyStimulus("reset_in_popb", 1'b1, 1'b1, 3'b001, '0, 1'b1, idle(0));

        // POP on an empty stack: underflow fault, no memory request.
        do_fetch(3'b101, 0, 0);
        do_decode(3'b101, 0, '0);
        applyStimulus("underflow", 1'b0, 1'b1, 3'b101, '0, 1'b1, fault_v(0, 2'b01));
        applyStimulus("underflow_hold", 1'b0, 1'b1, 3'b100, '0, 1'b1, fault_v(0, 2'b01));
        applyStimulus("reset_clears", 1'b1, 1'b1, 3'b000, '0, 1'b1, idle(0));

        // Fill to DEPTH, then PUSH once more: overflow fault with count frozen.
        do_push(0, 0, 0);
        do_push(1, 0, 0);
        do_push(2, 0, 0);
        do_push(3, 0, 0);
        do_fetch(3'b100, 0, 4);
        do_decode(3'b100, 4, '0);
        applyStimulus("overflow", 1'b0, 1'b1, 3'b100, '0, 1'b1, fault_v(4, 2'b10));
        applyStimulus("overflow_hold", 1'b0, 1'b1, 3'b000, '0, 1'b1, fault_v(4, 2'b10));
        applyStimulus("overflow_hold2", 1'b0, 1'b1, 3'b101, '0, 1'b0, fault_v(4, 2'b10));
        applyStimulus("reset_final", 1'b1, 1'b0, 3'b000, '0, 1'b0, idle(0));
        applyStimulus("after_reset", 1'b0, 1'b0, 3'b000, '0, 1'b0, idle(0));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
